// File: rtl/jtag_dmi_sequencer.sv
// JTAG master that runs one RISC-V DMI access per request: optional IR load,
// access DR scan, Run-Test/Idle wait, then a NOP DR scan whose captured
// contents become the response.
module jtag_dmi_sequencer #(
  parameter int unsigned       CLK_DIV     = 4,
  parameter int unsigned       IR_LEN      = 5,
  parameter logic [IR_LEN-1:0] DMI_IR      = 5'h11,
  parameter int unsigned       ABITS       = 7,
  parameter int unsigned       IDLE_CYCLES = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       req_op_i,
  input  logic [ABITS-1:0] req_addr_i,
  input  logic [31:0]      req_data_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_data_o,
  output logic [1:0]       rsp_op_o,
  output logic             busy_o,
  output logic             jtag_tck_o,
  output logic             jtag_tms_o,
  output logic             jtag_tdi_o,
  output logic             jtag_trst_no,
  input  logic             jtag_tdo_i
);

  localparam int unsigned DR_LEN = ABITS + 34;
  localparam int unsigned CNT_W  = $clog2(ABITS + 35);
  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CNT_W-1:0]  IR_LAST   = CNT_W'(IR_LEN - 1);
  localparam logic [CNT_W-1:0]  DR_LAST   = CNT_W'(DR_LEN - 1);
  localparam logic [CNT_W-1:0]  IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [DR_LEN-1:0] IR_VEC    = DR_LEN'(DMI_IR);

  typedef enum logic [3:0] {
    S_TRST, S_TLR, S_IDLE,
    S_IR_SEL, S_IR_SHIFT, S_IR_UPD,
    S_DR_SEL, S_DR_SHIFT, S_DR_UPD,
    S_RTI_WAIT,
    S_RB_SEL, S_RB_SHIFT, S_RB_UPD,
    S_RSP
  } state_t;

  state_t             state_q, state_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n, cnt_inc;
  logic               tms_q, tms_n;
  logic               tdi_q, tdi_n;
  logic               trst_n_q, trst_n_n;
  logic               ir_loaded_q, ir_loaded_n;
  logic [DR_LEN-1:0]  sr_q, sr_n;
  logic [DR_LEN-1:0]  req_q, req_n;
  logic [DIV_W-1:0]   div_q;
  logic               tck_q;
  logic [33:0]        cap_q;
  logic               rsp_valid_q;
  logic [31:0]        rsp_data_q;
  logic [1:0]         rsp_op_q;

  logic active, div_last, tck_fall, tck_rise, accept;

  assign active   = (state_q != S_IDLE) && (state_q != S_RSP);
  assign div_last = (div_q == DIV_W'(CLK_DIV - 1));
  assign tck_fall = active && tck_q && div_last;
  assign tck_rise = active && !tck_q && div_last;
  assign accept   = (state_q == S_IDLE) && req_valid_i && !rsp_valid_q;
  assign cnt_inc  = cnt_q + CNT_W'(1);

  // TCK divider: toggles every CLK_DIV clocks while a sequence runs, parked low otherwise
  always_ff @(posedge clk_i) begin
    if (rst_i || !active) begin
      div_q <= '0;
      tck_q <= 1'b0;
    end else if (div_last) begin
      div_q <= '0;
      tck_q <= ~tck_q;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // Sequencer next state: each TCK period is one step; a step ends on the TCK falling edge,
  // where TMS/TDI for the following period are chosen
  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    tms_n       = tms_q;
    tdi_n       = tdi_q;
    trst_n_n    = trst_n_q;
    ir_loaded_n = ir_loaded_q;
    sr_n        = sr_q;
    req_n       = req_q;
    case (state_q)
      S_TRST: if (tck_fall) begin
        tms_n = 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_n  = S_TLR;
          cnt_n    = '0;
          trst_n_n = 1'b1;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      S_TLR: if (tck_fall) begin
        if (cnt_q == CNT_W'(5)) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_inc;
          tms_n = (cnt_inc != CNT_W'(5));
        end
      end
      S_IDLE: if (accept) begin
        req_n   = {req_addr_i, req_data_i, req_op_i};
        cnt_n   = '0;
        tms_n   = 1'b1;
        tdi_n   = 1'b0;
        state_n = ir_loaded_q ? S_DR_SEL : S_IR_SEL;
      end
      S_IR_SEL: if (tck_fall) begin
        if (cnt_q == CNT_W'(3)) begin
          state_n = S_IR_SHIFT;
          cnt_n   = '0;
          sr_n    = IR_VEC;
          tdi_n   = IR_VEC[0];
          tms_n   = (IR_LEN == 1);
        end else begin
          cnt_n = cnt_inc;
          tms_n = (cnt_inc == CNT_W'(1));
        end
      end
      S_IR_SHIFT: if (tck_fall) begin
        if (cnt_q == IR_LAST) begin
          state_n = S_IR_UPD;
          cnt_n   = '0;
          tms_n   = 1'b1;
          tdi_n   = 1'b0;
        end else begin
          cnt_n = cnt_inc;
          sr_n  = sr_q >> 1;
          tdi_n = sr_q[1];
          tms_n = (cnt_inc == IR_LAST);
        end
      end
      S_IR_UPD: if (tck_fall) begin
        if (cnt_q == CNT_W'(1)) begin
          state_n     = S_DR_SEL;
          cnt_n       = '0;
          tms_n       = 1'b1;
          ir_loaded_n = 1'b1;
        end else begin
          cnt_n = cnt_inc;
          tms_n = 1'b0;
        end
      end
      S_DR_SEL, S_RB_SEL: if (tck_fall) begin
        if (cnt_q == CNT_W'(2)) begin
          state_n = (state_q == S_DR_SEL) ? S_DR_SHIFT : S_RB_SHIFT;
          cnt_n   = '0;
          sr_n    = (state_q == S_DR_SEL) ? req_q : '0;
          tdi_n   = (state_q == S_DR_SEL) ? req_q[0] : 1'b0;
          tms_n   = 1'b0;
        end else begin
          cnt_n = cnt_inc;
          tms_n = 1'b0;
        end
      end
      S_DR_SHIFT, S_RB_SHIFT: if (tck_fall) begin
        if (cnt_q == DR_LAST) begin
          state_n = (state_q == S_DR_SHIFT) ? S_DR_UPD : S_RB_UPD;
          cnt_n   = '0;
          tms_n   = 1'b1;
          tdi_n   = 1'b0;
        end else begin
          cnt_n = cnt_inc;
          sr_n  = sr_q >> 1;
          tdi_n = sr_q[1];
          tms_n = (cnt_inc == DR_LAST);
        end
      end
      S_DR_UPD: if (tck_fall) begin
        tms_n = 1'b0;
        if (cnt_q == CNT_W'(1)) begin
          state_n = S_RTI_WAIT;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      S_RTI_WAIT: if (tck_fall) begin
        if (cnt_q == IDLE_LAST) begin
          state_n = S_RB_SEL;
          cnt_n   = '0;
          tms_n   = 1'b1;
        end else begin
          cnt_n = cnt_inc;
          tms_n = 1'b0;
        end
      end
      S_RB_UPD: if (tck_fall) begin
        tms_n = 1'b0;
        if (cnt_q == CNT_W'(1)) begin
          state_n = S_RSP;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      S_RSP: state_n = S_IDLE;
      default: state_n = S_TRST;
    endcase
  end

  // Sequencer state register; reset restarts from TAP reset and forgets the loaded IR
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_TRST;
      cnt_q       <= '0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      trst_n_q    <= 1'b0;
      ir_loaded_q <= 1'b0;
      sr_q        <= '0;
      req_q       <= '0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      tms_q       <= tms_n;
      tdi_q       <= tdi_n;
      trst_n_q    <= trst_n_n;
      ir_loaded_q <= ir_loaded_n;
      sr_q        <= sr_n;
      req_q       <= req_n;
    end
  end

  // Readback capture: TDO sampled on TCK rise; only the low 34 bits {data,op} are kept
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cap_q <= '0;
    end else if (tck_rise && (state_q == S_RB_SHIFT) && (cnt_q < CNT_W'(34))) begin
      cap_q <= {jtag_tdo_i, cap_q[33:1]};
    end
  end

  // Response holding register: stays stable until the requester takes it
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_op_q    <= '0;
    end else if (state_q == S_RSP) begin
      rsp_valid_q <= 1'b1;
      rsp_data_q  <= cap_q[33:2];
      rsp_op_q    <= cap_q[1:0];
    end else if (rsp_valid_q && rsp_ready_i) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign req_ready_o  = (state_q == S_IDLE) && !rsp_valid_q;
  assign busy_o       = (state_q != S_IDLE);
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_data_o   = rsp_data_q;
  assign rsp_op_o     = rsp_op_q;
  assign jtag_tck_o   = tck_q;
  assign jtag_tms_o   = tms_q;
  assign jtag_tdi_o   = tdi_q;
  assign jtag_trst_no = trst_n_q;

endmodule

// File: tb/tb_jtag_dmi_sequencer.sv
// Bench for jtag_dmi_sequencer: behavioural TAP + DMI slave on the pins,
// table-driven and randomized requests, backpressure and mid-scan reset.
module tb_jtag_dmi_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [1:0]  req_op_i = '0;
  logic [6:0]  req_addr_i = '0;
  logic [31:0] req_data_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_data_o;
  logic [1:0]  rsp_op_o;
  logic        busy_o;
  logic        jtag_tck_o, jtag_tms_o, jtag_tdi_o, jtag_trst_no;
  logic        tap_tdo = 1'b0;

  int checks = 0;
  int failures = 0;

  jtag_dmi_sequencer dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_op_o(rsp_op_o), .busy_o(busy_o),
    .jtag_tck_o(jtag_tck_o), .jtag_tms_o(jtag_tms_o), .jtag_tdi_o(jtag_tdi_o),
    .jtag_trst_no(jtag_trst_no), .jtag_tdo_i(tap_tdo)
  );

  // System clock
  always #5 clk_i = ~clk_i;

  // Behavioural IEEE 1149.1 TAP with a DMI data register and a tiny DMI slave
  typedef enum int {
    T_TLR, T_RTI, T_SDR, T_CDR, T_SHDR, T_E1DR, T_PDR, T_E2DR, T_UDR,
    T_SIR, T_CIR, T_SHIR, T_E1IR, T_PIR, T_E2IR, T_UIR
  } tap_t;

  tap_t        tap_st = T_TLR;
  logic [4:0]  tap_ir = 5'h01;
  logic [4:0]  ir_sr = '0;
  logic [40:0] dr_sr = '0;
  logic [40:0] last_dr = '0;
  logic [6:0]  slv_addr = '0;
  logic [31:0] slv_rdata = '0;
  logic [1:0]  slv_status = '0;
  logic [1:0]  inject_status = '0;
  logic [31:0] slv_mem [128] = '{default: 32'h0};
  int          tap_shift_cnt = 0;
  int          ir_upd_cnt = 0;
  int          access_cnt = 0;

  function automatic tap_t tap_next(input tap_t s, input logic tms);
    case (s)
      T_TLR:   return tms ? T_TLR  : T_RTI;
      T_RTI:   return tms ? T_SDR  : T_RTI;
      T_SDR:   return tms ? T_SIR  : T_CDR;
      T_CDR:   return tms ? T_E1DR : T_SHDR;
      T_SHDR:  return tms ? T_E1DR : T_SHDR;
      T_E1DR:  return tms ? T_UDR  : T_PDR;
      T_PDR:   return tms ? T_E2DR : T_PDR;
      T_E2DR:  return tms ? T_UDR  : T_SHDR;
      T_UDR:   return tms ? T_SDR  : T_RTI;
      T_SIR:   return tms ? T_TLR  : T_CIR;
      T_CIR:   return tms ? T_E1IR : T_SHIR;
      T_SHIR:  return tms ? T_E1IR : T_SHIR;
      T_E1IR:  return tms ? T_UIR  : T_PIR;
      T_PIR:   return tms ? T_E2IR : T_PIR;
      T_E2IR:  return tms ? T_UIR  : T_SHIR;
      default: return tms ? T_SDR  : T_RTI;
    endcase
  endfunction

  // TAP register actions on TCK rise, then state advance
  always @(posedge jtag_tck_o or negedge jtag_trst_no) begin
    if (!jtag_trst_no) begin
      tap_st = T_TLR;
      tap_ir = 5'h01;
    end else begin
      case (tap_st)
        T_TLR: tap_ir = 5'h01;
        T_CDR: begin
          dr_sr = (tap_ir == 5'h11) ? {slv_addr, slv_rdata, slv_status} : '0;
          tap_shift_cnt = 0;
        end
        T_SHDR: begin
          dr_sr = {jtag_tdi_o, dr_sr[40:1]};
          tap_shift_cnt++;
        end
        T_UDR: if (tap_ir == 5'h11) begin
          slv_addr   = dr_sr[40:34];
          slv_status = inject_status;
          slv_rdata  = (dr_sr[1:0] == 2'd1) ? slv_mem[dr_sr[40:34]] : 32'h0;
          if (dr_sr[1:0] == 2'd2) slv_mem[dr_sr[40:34]] = dr_sr[33:2];
          if (dr_sr[1:0] != 2'd0) begin
            last_dr = dr_sr;
            access_cnt++;
          end
        end
        T_CIR:  ir_sr = 5'h01;
        T_SHIR: ir_sr = {jtag_tdi_o, ir_sr[4:1]};
        T_UIR: begin
          tap_ir = ir_sr;
          ir_upd_cnt++;
        end
        default: ;
      endcase
      tap_st = tap_next(tap_st, jtag_tms_o);
    end
  end

  // TDO changes on TCK fall
  always @(negedge jtag_tck_o) begin
    tap_tdo = (tap_st == T_SHDR) ? dr_sr[0] : ((tap_st == T_SHIR) ? ir_sr[0] : 1'b0);
  end

  // Global safety net
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Issue one request and wait for its response (left pending for the caller)
  task automatic applyStimulus(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data,
                               output logic [31:0] r_data, output logic [1:0] r_op, output bit got);
    int n;
    got = 0;
    r_data = '0;
    r_op = '0;
    n = 0;
    while (!req_ready_o && n < 5000) begin @(negedge clk_i); n++; end
    if (!req_ready_o) begin
      checkOutput("accept_timeout", req_ready_o, 1);
      return;
    end
    req_valid_i = 1'b1;
    req_op_i = op;
    req_addr_i = addr;
    req_data_i = data;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    n = 0;
    while (!rsp_valid_o && n < 5000) begin @(negedge clk_i); n++; end
    if (!rsp_valid_o) begin
      checkOutput("rsp_timeout", rsp_valid_o, 1);
      return;
    end
    r_data = rsp_data_o;
    r_op = rsp_op_o;
    got = 1;
  endtask

  task automatic consume();
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [6:0]  addr;
    logic [31:0] data;
    logic [1:0]  inj;
    logic [31:0] exp_data;
    logic [1:0]  exp_op;
  } vec_t;

  logic [31:0] ref_mem [128] = '{default: 32'h0};

  initial begin
    vec_t        vecs [6];
    logic [31:0] r_data, snap_data;
    logic [1:0]  r_op, snap_op;
    bit          got;
    logic        prev_tck;
    logic [5:0]  tms_seen;
    int          rise_cyc [6];
    int          k, n, bad, ir_before;
    logic [1:0]  rop;
    logic [6:0]  raddr;
    logic [31:0] rdat, exp_d;
    logic [1:0]  inj;

    vecs[0] = '{2'd2, 7'h10, 32'h00000001, 2'd0, 32'h0,        2'd0};
    vecs[1] = '{2'd2, 7'h11, 32'h00000C82, 2'd0, 32'h0,        2'd0};
    vecs[2] = '{2'd1, 7'h11, 32'h0,        2'd0, 32'h00000C82, 2'd0};
    vecs[3] = '{2'd1, 7'h10, 32'h0,        2'd3, 32'h00000001, 2'd3};
    vecs[4] = '{2'd1, 7'h11, 32'h0,        2'd0, 32'h00000C82, 2'd0};
    vecs[5] = '{2'd3, 7'h05, 32'hDEADBEEF, 2'd0, 32'h0,        2'd0};

    // Reset values while rst_i is held
    repeat (4) @(negedge clk_i);
    checkOutput("reset_outputs",
                {jtag_tck_o, jtag_tms_o, jtag_tdi_o, jtag_trst_no, req_ready_o, rsp_valid_o, busy_o},
                7'b0100_001);
    checkOutput("reset_rsp", {rsp_data_o, rsp_op_o}, 34'h0);

    // Reset release: TRSTn low two TCK periods, then TLR TMS pattern
    rst_i = 1'b0;
    n = 0;
    while (!jtag_trst_no && n < 100) begin @(negedge clk_i); n++; end
    checkOutput("trst_low_clks", n, 16);
    prev_tck = jtag_tck_o;
    tms_seen = '0;
    k = 0;
    n = 0;
    while (k < 6 && n < 500) begin
      @(negedge clk_i);
      n++;
      if (jtag_tck_o && !prev_tck) begin
        tms_seen[k] = jtag_tms_o;
        rise_cyc[k] = n;
        k++;
      end
      prev_tck = jtag_tck_o;
    end
    checkOutput("tlr_tms", tms_seen, 6'b011111);
    checkOutput("tck_period", (k >= 2) ? (rise_cyc[1] - rise_cyc[0]) : 0, 8);
    n = 0;
    while (!req_ready_o && n < 100) begin @(negedge clk_i); n++; end
    checkOutput("ready_after_tlr", {req_ready_o, busy_o}, 2'b10);

    // Directed table
    for (int i = 0; i < 6; i++) begin
      inject_status = vecs[i].inj;
      applyStimulus(vecs[i].op, vecs[i].addr, vecs[i].data, r_data, r_op, got);
      if (got) begin
        checkOutput($sformatf("vec%0d_data", i), r_data, vecs[i].exp_data);
        checkOutput($sformatf("vec%0d_op", i), r_op, vecs[i].exp_op);
        checkOutput($sformatf("vec%0d_dr", i), last_dr, {vecs[i].addr, vecs[i].data, vecs[i].op});
        consume();
      end
      if (vecs[i].op == 2'd2) ref_mem[vecs[i].addr] = vecs[i].data;
      if (i == 0) checkOutput("first_ir", {ir_upd_cnt[7:0], 3'b0, tap_ir}, {8'd1, 8'h11});
      if (i == 2) checkOutput("no_ir_rescan", ir_upd_cnt, 1);
    end
    inject_status = 2'd0;

    // Backpressure with a competing request held on the input
    applyStimulus(2'd1, 7'h11, 32'h0, r_data, r_op, got);
    if (got) begin
      snap_data = rsp_data_o;
      snap_op = rsp_op_o;
      req_valid_i = 1'b1;
      req_op_i = 2'd2;
      req_addr_i = 7'h10;
      req_data_i = 32'h55;
      bad = 0;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk_i);
        if (!rsp_valid_o || rsp_data_o !== snap_data || rsp_op_o !== snap_op || req_ready_o) bad++;
      end
      checkOutput("bp_stable_cycles_bad", bad, 0);
      checkOutput("bp_data", snap_data, 32'h00000C82);
      rsp_ready_i = 1'b1;
      req_valid_i = 1'b0;
      @(negedge clk_i);
      rsp_ready_i = 1'b0;
      checkOutput("bp_release", {rsp_valid_o, req_ready_o}, 2'b01);
    end
    applyStimulus(2'd1, 7'h10, 32'h0, r_data, r_op, got);
    if (got) begin
      checkOutput("bp_no_stray_write", r_data, ref_mem[7'h10]);
      consume();
    end

    // Randomized requests against the reference memory
    for (int i = 0; i < 12; i++) begin
      rop = 2'($urandom_range(0, 2));
      raddr = 7'($urandom_range(0, 7));
      rdat = $urandom;
      case ($urandom_range(0, 3))
        0, 1:    inj = 2'd0;
        2:       inj = 2'd2;
        default: inj = 2'd3;
      endcase
      inject_status = inj;
      exp_d = (rop == 2'd1) ? ref_mem[raddr] : 32'h0;
      applyStimulus(rop, raddr, rdat, r_data, r_op, got);
      if (got) begin
        checkOutput($sformatf("rnd%0d_rsp", i), {r_data, r_op}, {exp_d, inj});
        repeat ($urandom_range(0, 4)) @(negedge clk_i);
        consume();
      end
      if (rop == 2'd2) ref_mem[raddr] = rdat;
    end
    inject_status = 2'd0;

    // Reset in the middle of the access DR scan
    n = 0;
    while (!req_ready_o && n < 5000) begin @(negedge clk_i); n++; end
    req_valid_i = 1'b1;
    req_op_i = 2'd2;
    req_addr_i = 7'h20;
    req_data_i = 32'hABCD1234;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    n = 0;
    while (!(tap_st == T_SHDR && tap_shift_cnt == 20) && n < 5000) begin @(negedge clk_i); n++; end
    checkOutput("mid_reset_reached", tap_shift_cnt, 20);
    rst_i = 1'b1;
    @(negedge clk_i);
    checkOutput("mid_reset_pins", {jtag_trst_no, jtag_tms_o, busy_o, rsp_valid_o}, 4'b0110);
    rst_i = 1'b0;
    ir_before = ir_upd_cnt;
    bad = 0;
    n = 0;
    while (!req_ready_o && n < 1000) begin
      @(negedge clk_i);
      n++;
      if (rsp_valid_o) bad++;
    end
    checkOutput("no_stale_rsp", bad, 0);
    applyStimulus(2'd1, 7'h20, 32'h0, r_data, r_op, got);
    if (got) begin
      checkOutput("after_reset_rsp", {r_data, r_op}, {ref_mem[7'h20], 2'd0});
      consume();
    end
    checkOutput("ir_rescan_after_reset", ir_upd_cnt - ir_before, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
